// File: rtl/wsel_decoder_seq.sv
// wsel_decoder_seq: registered one-hot write-select decoder with a hardware sweep mode
module wsel_decoder_seq #(
    parameter int ADDR_W    = 5,
    parameter bit ZERO_LOCK = 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  sweep_start,
    output logic [2**ADDR_W-1:0]  out,
    output logic                  out_valid,
    output logic                  sweep_busy,
    output logic                  sweep_done,
    output logic                  zero_hit
);
    localparam int NUM_OUT = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] FIRST = ZERO_LOCK ? ADDR_W'(1) : ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic [NUM_OUT-1:0]   out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 sweep_done_q, sweep_done_d;
    logic                 zero_hit_q, zero_hit_d;

    assign req_ready  = (state_q == IDLE) && !sweep_start;
    assign sweep_busy = state_q == SWEEP;
    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign sweep_done = sweep_done_q;
    assign zero_hit   = zero_hit_q;

    // next state: idx_q is the index currently shown on out during a sweep
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        out_d        = '0;
        out_valid_d  = 1'b0;
        sweep_done_d = 1'b0;
        zero_hit_d   = 1'b0;
        if (state_q == IDLE) begin
            if (sweep_start) begin
                state_d      = SWEEP;
                idx_d        = FIRST;
                out_d        = NUM_OUT'(1) << FIRST;
                out_valid_d  = 1'b1;
                sweep_done_d = FIRST == LAST;
            end else if (req_valid) begin
                zero_hit_d  = ZERO_LOCK && (req_addr == '0);
                out_d       = zero_hit_d ? '0 : NUM_OUT'(1) << req_addr;
                out_valid_d = 1'b1;
            end
        end else if (idx_q == LAST) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            idx_d        = idx_q + ADDR_W'(1);
            out_d        = NUM_OUT'(1) << idx_d;
            out_valid_d  = 1'b1;
            sweep_done_d = idx_d == LAST;
        end
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            sweep_done_q <= 1'b0;
            zero_hit_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            sweep_done_q <= sweep_done_d;
            zero_hit_q   <= zero_hit_d;
        end
    end
endmodule

// File: tb/tb_wsel_decoder_seq.sv
// tb_wsel_decoder_seq: directed checks of the write-select decoder in three configurations
module tb_wsel_decoder_seq;
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    logic        a_valid = 0, a_sweep = 0, a_ready, a_ov, a_busy, a_done, a_zh;
    logic [4:0]  a_addr = 0;
    logic [31:0] a_out;
    logic        z_valid = 0, z_sweep = 0, z_ready, z_ov, z_busy, z_done, z_zh;
    logic [4:0]  z_addr = 0;
    logic [31:0] z_out;
    logic        t_valid = 0, t_sweep = 0, t_ready, t_ov, t_busy, t_done, t_zh;
    logic [2:0]  t_addr = 0;
    logic [7:0]  t_out;

    always #5 clock = ~clock;

    wsel_decoder_seq #(.ADDR_W(5), .ZERO_LOCK(1)) dut (
        .clock(clock), .ctrl_reset_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
        .req_addr(a_addr), .sweep_start(a_sweep), .out(a_out), .out_valid(a_ov),
        .sweep_busy(a_busy), .sweep_done(a_done), .zero_hit(a_zh));
    wsel_decoder_seq #(.ADDR_W(5), .ZERO_LOCK(0)) dut_z (
        .clock(clock), .ctrl_reset_n(rst_n), .req_valid(z_valid), .req_ready(z_ready),
        .req_addr(z_addr), .sweep_start(z_sweep), .out(z_out), .out_valid(z_ov),
        .sweep_busy(z_busy), .sweep_done(z_done), .zero_hit(z_zh));
    wsel_decoder_seq #(.ADDR_W(3), .ZERO_LOCK(1)) dut_t (
        .clock(clock), .ctrl_reset_n(rst_n), .req_valid(t_valid), .req_ready(t_ready),
        .req_addr(t_addr), .sweep_start(t_sweep), .out(t_out), .out_valid(t_ov),
        .sweep_busy(t_busy), .sweep_done(t_done), .zero_hit(t_zh));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_out", a_out, 32'h0);
        chk("rst_ov", 32'(a_ov), 32'h0);
        chk("rst_busy", 32'(a_busy), 32'h0);
        chk("rst_done", 32'(a_done), 32'h0);
        chk("rst_zh", 32'(a_zh), 32'h0);
        chk("rst_ready", 32'(a_ready), 32'h1);
        rst_n = 1'b1;

        a_valid = 1; a_addr = 7;
        tick();
        chk("t1_out", a_out, 32'h0000_0080);
        chk("t1_ov", 32'(a_ov), 32'h1);
        a_valid = 0;
        tick();
        chk("t1_idle_out", a_out, 32'h0);
        chk("t1_idle_ov", 32'(a_ov), 32'h0);

        a_valid = 1; a_addr = 31;
        tick();
        chk("t2_a31", a_out, 32'h8000_0000);
        chk("t2_a31_zh", 32'(a_zh), 32'h0);
        a_addr = 0;
        tick();
        chk("t2_a0", a_out, 32'h0);
        chk("t2_a0_ov", 32'(a_ov), 32'h1);
        chk("t2_a0_zh", 32'(a_zh), 32'h1);
        a_addr = 16;
        tick();
        chk("t2_a16", a_out, 32'h0001_0000);
        chk("t2_a16_zh", 32'(a_zh), 32'h0);
        a_valid = 0;
        tick();
        chk("t2_idle_ov", 32'(a_ov), 32'h0);
        chk("t2_idle_zh", 32'(a_zh), 32'h0);

        a_sweep = 1; a_valid = 1; a_addr = 3;
        #1;
        chk("t3_ready_lo", 32'(a_ready), 32'h0);
        tick();
        a_sweep = 0; a_valid = 0;
        for (int i = 1; i <= 31; i++) begin
            a_valid = (i >= 10 && i <= 12); a_sweep = (i >= 10 && i <= 12); a_addr = 5;
            #1;
            chk($sformatf("t3_out%0d", i), a_out, 32'd1 << i);
            chk($sformatf("t3_ov%0d", i), 32'(a_ov), 32'h1);
            chk($sformatf("t3_busy%0d", i), 32'(a_busy), 32'h1);
            chk($sformatf("t3_done%0d", i), 32'(a_done), 32'(i == 31));
            chk($sformatf("t3_zh%0d", i), 32'(a_zh), 32'h0);
            chk($sformatf("t3_rdy%0d", i), 32'(a_ready), 32'h0);
            tick();
        end
        a_valid = 0; a_sweep = 0;
        #1;
        chk("t3_end_out", a_out, 32'h0);
        chk("t3_end_ov", 32'(a_ov), 32'h0);
        chk("t3_end_busy", 32'(a_busy), 32'h0);
        chk("t3_end_done", 32'(a_done), 32'h0);
        chk("t3_end_ready", 32'(a_ready), 32'h1);

        a_sweep = 1;
        tick();
        a_sweep = 0;
        repeat (9) tick();
        chk("t5_pre_out", a_out, 32'h0000_0400);
        rst_n = 0;
        #1;
        chk("t5_rst_out", a_out, 32'h0);
        chk("t5_rst_ov", 32'(a_ov), 32'h0);
        chk("t5_rst_busy", 32'(a_busy), 32'h0);
        tick();
        rst_n = 1;
        #1;
        chk("t5_ready", 32'(a_ready), 32'h1);
        chk("t5_idle_out", a_out, 32'h0);
        a_sweep = 1;
        tick();
        a_sweep = 0;
        chk("t5_first", a_out, 32'h0000_0002);
        chk("t5_busy", 32'(a_busy), 32'h1);
        repeat (31) tick();
        chk("t5_end_busy", 32'(a_busy), 32'h0);

        z_sweep = 1;
        tick();
        z_sweep = 0;
        for (int i = 0; i <= 31; i++) begin
            chk($sformatf("t4_out%0d", i), z_out, 32'd1 << i);
            chk($sformatf("t4_done%0d", i), 32'(z_done), 32'(i == 31));
            tick();
        end
        chk("t4_end_busy", 32'(z_busy), 32'h0);
        chk("t4_end_ov", 32'(z_ov), 32'h0);
        z_valid = 1; z_addr = 0;
        tick();
        z_valid = 0;
        chk("t4_a0_out", z_out, 32'h1);
        chk("t4_a0_ov", 32'(z_ov), 32'h1);
        chk("t4_a0_zh", 32'(z_zh), 32'h0);

        t_valid = 1; t_addr = 5;
        tick();
        t_valid = 0;
        chk("t6_a5", 32'(t_out), 32'h20);
        t_sweep = 1;
        tick();
        t_sweep = 0;
        for (int i = 1; i <= 7; i++) begin
            chk($sformatf("t6_out%0d", i), 32'(t_out), 32'd1 << i);
            chk($sformatf("t6_done%0d", i), 32'(t_done), 32'(i == 7));
            tick();
        end
        chk("t6_end_busy", 32'(t_busy), 32'h0);
        chk("t6_end_out", 32'(t_out), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
